// File: rtl/jzjpcc_memory_pkg.sv
// Shared types for the memory stage.
//  - mem_funct3_e : RV32I load/store funct3 encodings
//  - em_reg_t     : execute->memory pipeline register contents
//  - mw_reg_t     : memory->writeback pipeline register contents
//  - mem_fault()  : misalignment / illegal-funct3 detection
package jzjpcc_memory_pkg;

    typedef enum logic [2:0] {
        F3Byte  = 3'b000,
        F3Half  = 3'b001,
        F3Word  = 3'b010,
        F3ByteU = 3'b100,
        F3HalfU = 3'b101
    } mem_funct3_e;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] rs2;
        logic [4:0]  rd_addr;
        logic        rd_we;
        logic        mem_read;
        logic        mem_write;
        logic [2:0]  funct3;
    } em_reg_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [4:0]  rd_addr;
        logic        rd_we;
        logic        is_load;
        logic [2:0]  funct3;
        logic [1:0]  off;
    } mw_reg_t;

    localparam em_reg_t EmBubble = '0;
    localparam mw_reg_t MwBubble = '0;

    // True when the access is misaligned for its size or funct3 has no load/store meaning.
    function automatic logic mem_fault(input logic [2:0] funct3, input logic [1:0] off);
        logic fault;
        case (funct3)
            F3Byte, F3ByteU: fault = 1'b0;
            F3Half, F3HalfU: fault = off[0];
            F3Word:          fault = (off != 2'b00);
            default:         fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/jzjpcc_loadalign.sv
// Combinational load alignment: selects the addressed byte/halfword of the RAM read word and
// sign- or zero-extends it according to funct3.
//  funct3_i : load funct3 (LB/LH/LW/LBU/LHU)
//  off_i    : byte offset within the word
//  word_i   : raw RAM read word
//  data_o   : extended value for rd (0 for non-load encodings)
module jzjpcc_loadalign
    import jzjpcc_memory_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{off_i, 3'b000} +: 8];
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
        data_o   = '0;
        case (funct3_i)
            F3Byte:  data_o = {{24{byte_sel[7]}}, byte_sel};
            F3Half:  data_o = {{16{half_sel[15]}}, half_sel};
            F3Word:  data_o = word_i;
            F3ByteU: data_o = {24'h000000, byte_sel};
            F3HalfU: data_o = {16'h0000, half_sel};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/jzjpcc_memory.sv
// Memory stage of the pipeline.
// Holds the execute->memory register, drives the synchronous data RAM (word address, lane-steered
// store data, byte enables, write strobe), holds the memory->writeback register and produces the
// aligned/extended writeback value.
//  clock/reset            : rising-edge clock, synchronous active-high reset
//  stall_memory           : hold E->M, inject bubble into M->W
//  flush_memory           : inject bubble into E->M (wins over stall)
//  *_execute              : instruction fields from execute
//  dm*                    : data RAM interface (read data valid one cycle after dmAddr)
//  *_memory               : memory-stage info for forwarding/hazards
//  *_writeback            : final rd write
module jzjpcc_memory
    import jzjpcc_memory_pkg::*;
#(
    parameter int unsigned RAM_A_WIDTH = 12
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall_memory,
    input  logic                   flush_memory,
    input  logic [31:0]            aluResult_execute,
    input  logic [31:0]            rs2_execute,
    input  logic [4:0]             rdAddr_execute,
    input  logic                   rdWriteEnable_execute,
    input  logic                   memRead_execute,
    input  logic                   memWrite_execute,
    input  logic [2:0]             memFunct3_execute,
    output logic [RAM_A_WIDTH-3:0] dmAddr,
    output logic [31:0]            dmWriteData,
    output logic [3:0]             dmByteEnable,
    output logic                   dmWriteEnable,
    input  logic [31:0]            dmReadData,
    output logic [31:0]            aluResult_memory,
    output logic [4:0]             rdAddr_memory,
    output logic                   rdWriteEnable_memory,
    output logic                   memFault_memory,
    output logic [31:0]            rdData_writeback,
    output logic [4:0]             rdAddr_writeback,
    output logic                   rdWriteEnable_writeback
);

    em_reg_t em_q, em_d;
    mw_reg_t mw_q, mw_d;

    logic [1:0]  off;
    logic        fault;
    logic        rd_we_mem;
    logic [31:0] store_data;
    logic [3:0]  store_be;
    logic [31:0] load_data;

    // E->M next state: flush beats stall.
    always_comb begin
        em_d = em_q;
        if (flush_memory) begin
            em_d = EmBubble;
        end else if (!stall_memory) begin
            em_d.alu_result = aluResult_execute;
            em_d.rs2        = rs2_execute;
            em_d.rd_addr    = rdAddr_execute;
            em_d.rd_we      = rdWriteEnable_execute;
            em_d.mem_read   = memRead_execute;
            em_d.mem_write  = memWrite_execute;
            em_d.funct3     = memFunct3_execute;
        end
    end

    assign off       = em_q.alu_result[1:0];
    assign fault     = (em_q.mem_read | em_q.mem_write) & mem_fault(em_q.funct3, off);
    assign rd_we_mem = em_q.rd_we & ~fault;

    // Store lane steering; size comes from funct3[1:0].
    always_comb begin
        store_data = em_q.rs2;
        store_be   = 4'b1111;
        case (em_q.funct3[1:0])
            2'b00: begin
                store_data = {4{em_q.rs2[7:0]}};
                store_be   = 4'b0001 << off;
            end
            2'b01: begin
                store_data = {2{em_q.rs2[15:0]}};
                store_be   = off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                store_data = em_q.rs2;
                store_be   = 4'b1111;
            end
        endcase
    end

    assign dmAddr       = em_q.alu_result[RAM_A_WIDTH-1:2];
    assign dmWriteData  = store_data;
    assign dmByteEnable = em_q.mem_write ? store_be : 4'b0000;
    // A stalled store writes only once, on the cycle it is released; reset blocks the write too.
    assign dmWriteEnable = em_q.mem_write & ~fault & ~stall_memory & ~reset;

    assign aluResult_memory     = em_q.alu_result;
    assign rdAddr_memory        = em_q.rd_addr;
    assign rdWriteEnable_memory = rd_we_mem;
    assign memFault_memory      = fault;

    // M->W next state: a stall sends a bubble so the held instruction is not written back twice.
    always_comb begin
        mw_d = MwBubble;
        if (!stall_memory) begin
            mw_d.alu_result = em_q.alu_result;
            mw_d.rd_addr    = em_q.rd_addr;
            mw_d.rd_we      = rd_we_mem;
            mw_d.is_load    = em_q.mem_read & ~fault;
            mw_d.funct3     = em_q.funct3;
            mw_d.off        = off;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            em_q <= EmBubble;
            mw_q <= MwBubble;
        end else begin
            em_q <= em_d;
            mw_q <= mw_d;
        end
    end

    jzjpcc_loadalign u_loadalign (
        .funct3_i (mw_q.funct3),
        .off_i    (mw_q.off),
        .word_i   (dmReadData),
        .data_o   (load_data)
    );

    assign rdData_writeback        = mw_q.is_load ? load_data : mw_q.alu_result;
    assign rdAddr_writeback        = mw_q.rd_addr;
    assign rdWriteEnable_writeback = mw_q.rd_we;

endmodule
